mult_div_unit: RTL and testbench

MULT_DIV_UNIT -- requirements
Module: mult_div_unit

---
 rtl/mult_div_unit.sv | 180 ++++++++++++++++++
 tb/tb_mult_div_unit.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit: shift-add multiply and restoring divide,
// one bit per cycle, with signed variants handled by magnitude plus sign fix-up.
module mult_div_unit #(
    parameter int BUS_W = 32
) (
    input  logic             reloj_cucu,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [BUS_W-1:0] rs_data,
    input  logic [BUS_W-1:0] rt_data,
    output logic             busy,
    output logic             done,
    output logic [BUS_W-1:0] hi,
    output logic [BUS_W-1:0] lo,
    output logic             div_by_zero
);

    localparam int CNT_W = $clog2(BUS_W);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BUS_W - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t           state_r, state_s;
    logic [CNT_W-1:0] cnt_r;
    logic [1:0]       op_r;
    logic [BUS_W-1:0] rs_r;
    logic [BUS_W-1:0] acc_hi_r, acc_lo_r, opnd_r;
    logic             neg_lo_r, neg_hi_r, dz_pend_r;
    logic             busy_r, done_r, div_by_zero_r;
    logic [BUS_W-1:0] hi_r, lo_r;

    logic             accept_s, last_s;
    logic [BUS_W:0]   mul_sum_s, div_shift_s;
    logic [BUS_W-1:0] div_diff_s;
    logic             div_ge_s;
    logic [BUS_W-1:0] step_hi_s, step_lo_s, res_hi_s, res_lo_s;
    logic [2*BUS_W-1:0] prod_s;

    function automatic logic [BUS_W-1:0] magnitude(input logic [BUS_W-1:0] v, input logic sgn);
        if (sgn && v[BUS_W-1]) begin
            magnitude = -v;
        end else begin
            magnitude = v;
        end
    endfunction

    assign accept_s = start && (state_r != RUN);
    assign last_s   = (cnt_r == LAST_CNT);

    // FSM state register
    always_ff @(posedge reloj_cucu or negedge reset) begin
        if (!reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) state_s = RUN;
                else          state_s = IDLE;
            end
            RUN: begin
                if (last_s) state_s = FIN;
                else        state_s = RUN;
            end
            FIN: begin
                if (accept_s) state_s = RUN;
                else          state_s = IDLE;
            end
            default: state_s = IDLE;
        endcase
    end

    // One iteration step and the sign-corrected final result
    always_comb begin
        mul_sum_s   = {1'b0, acc_hi_r} + (acc_lo_r[0] ? {1'b0, opnd_r} : {(BUS_W+1){1'b0}});
        div_shift_s = {acc_hi_r, acc_lo_r[BUS_W-1]};
        div_ge_s    = (div_shift_s >= {1'b0, opnd_r});
        // When div_ge_s holds the difference is below 2^BUS_W, so the carry bit is not needed
        div_diff_s  = div_shift_s[BUS_W-1:0] - opnd_r;
        if (op_r[1]) begin
            step_hi_s = div_ge_s ? div_diff_s : div_shift_s[BUS_W-1:0];
            step_lo_s = {acc_lo_r[BUS_W-2:0], div_ge_s};
        end else begin
            step_hi_s = mul_sum_s[BUS_W:1];
            step_lo_s = {mul_sum_s[0], acc_lo_r[BUS_W-1:1]};
        end
        prod_s = {step_hi_s, step_lo_s};
        if (!op_r[1]) begin
            if (neg_lo_r) prod_s = -prod_s;
            else          prod_s = prod_s;
            res_hi_s = prod_s[2*BUS_W-1:BUS_W];
            res_lo_s = prod_s[BUS_W-1:0];
        end else if (dz_pend_r) begin
            res_hi_s = rs_r;
            res_lo_s = {BUS_W{1'b1}};
        end else begin
            res_hi_s = neg_hi_r ? -step_hi_s : step_hi_s;
            res_lo_s = neg_lo_r ? -step_lo_s : step_lo_s;
        end
    end

    // Operand latch, iteration registers and result registers
    always_ff @(posedge reloj_cucu or negedge reset) begin
        if (!reset) begin
            cnt_r         <= '0;
            op_r          <= 2'b00;
            rs_r          <= '0;
            acc_hi_r      <= '0;
            acc_lo_r      <= '0;
            opnd_r        <= '0;
            neg_lo_r      <= 1'b0;
            neg_hi_r      <= 1'b0;
            dz_pend_r     <= 1'b0;
            hi_r          <= '0;
            lo_r          <= '0;
            div_by_zero_r <= 1'b0;
        end else if (accept_s) begin
            cnt_r         <= '0;
            op_r          <= op;
            rs_r          <= rs_data;
            acc_hi_r      <= '0;
            neg_lo_r      <= op[0] && (rs_data[BUS_W-1] ^ rt_data[BUS_W-1]);
            neg_hi_r      <= op[0] && rs_data[BUS_W-1];
            dz_pend_r     <= op[1] && (rt_data == '0);
            div_by_zero_r <= 1'b0;
            // Divide keeps the dividend in acc_lo; multiply keeps the multiplier there
            if (op[1]) begin
                acc_lo_r <= magnitude(rs_data, op[0]);
                opnd_r   <= magnitude(rt_data, op[0]);
            end else begin
                acc_lo_r <= magnitude(rt_data, op[0]);
                opnd_r   <= magnitude(rs_data, op[0]);
            end
        end else if (state_r == RUN) begin
            cnt_r    <= cnt_r + CNT_W'(1);
            acc_hi_r <= step_hi_s;
            acc_lo_r <= step_lo_s;
            if (last_s) begin
                hi_r          <= res_hi_s;
                lo_r          <= res_lo_s;
                div_by_zero_r <= dz_pend_r;
            end else begin
                hi_r          <= hi_r;
                lo_r          <= lo_r;
                div_by_zero_r <= div_by_zero_r;
            end
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // Registered status flags derived from the upcoming state
    always_ff @(posedge reloj_cucu or negedge reset) begin
        if (!reset) begin
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            busy_r <= (state_s == RUN);
            done_r <= (state_s == FIN);
        end
    end

    assign busy        = busy_r;
    assign done        = done_r;
    assign hi          = hi_r;
    assign lo          = lo_r;
    assign div_by_zero = div_by_zero_r;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed, table-driven bench for mult_div_unit with hand-written handshake
// and reset sequences.
module tb_mult_div_unit;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [1:0]  op;
    logic [31:0] rs_data, rt_data;
    logic        busy, done, div_by_zero;
    logic [31:0] hi, lo;

    int total = 0;
    int bad   = 0;
    logic [31:0] prev_hi, prev_lo;

    mult_div_unit #(.BUS_W(32)) dut (
        .reloj_cucu  (clk),
        .reset       (rst_n),
        .start       (start),
        .op          (op),
        .rs_data     (rs_data),
        .rt_data     (rt_data),
        .busy        (busy),
        .done        (done),
        .hi          (hi),
        .lo          (lo),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
    } vec_t;

    vec_t vecs[15];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive a request for one cycle, then scramble the operand inputs.
    task automatic launch(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        start = 1'b1; op = o; rs_data = a; rt_data = b;
        @(negedge clk);
        start = 1'b0;
        op = 2'($urandom); rs_data = $urandom; rt_data = $urandom;
    endtask

    // Walk until done (bounded), counting busy cycles and checking hi/lo hold.
    task automatic finish_op(input int pulse_at, output int bcnt, output logic held_ok);
        int guard;
        bcnt = 0; guard = 0; held_ok = 1'b1;
        while (done !== 1'b1 && guard < 100) begin
            if (busy === 1'b1) bcnt++;
            if (hi !== prev_hi || lo !== prev_lo) held_ok = 1'b0;
            if (bcnt == pulse_at) begin
                start = 1'b1; op = 2'($urandom); rs_data = $urandom; rt_data = $urandom;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            guard++;
        end
        start = 1'b0;
    endtask

    task automatic check_result(input string tag, input logic [31:0] eh, input logic [31:0] el,
                                input logic edz, input int bcnt, input logic held_ok);
        check({tag, "_done"}, 64'(done), 64'(1'b1));
        check({tag, "_busy_low"}, 64'(busy), 64'(1'b0));
        check({tag, "_hi"}, 64'(hi), 64'(eh));
        check({tag, "_lo"}, 64'(lo), 64'(el));
        check({tag, "_dz"}, 64'(div_by_zero), 64'(edz));
        check({tag, "_busy_cycles"}, 64'(bcnt), 64'd32);
        check({tag, "_held"}, 64'(held_ok), 64'(1'b1));
    endtask

    initial begin
        int bcnt;
        logic held_ok;

        vecs[0]  = '{2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0};
        vecs[1]  = '{2'b01, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0};
        vecs[2]  = '{2'b11, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
        vecs[3]  = '{2'b10, 32'd100,      32'd7,        32'd2,        32'd14,       1'b0};
        vecs[4]  = '{2'b10, 32'h00000064, 32'h00000000, 32'h00000064, 32'hFFFFFFFF, 1'b1};
        vecs[5]  = '{2'b00, 32'd3,        32'd5,        32'd0,        32'd15,       1'b0};
        vecs[6]  = '{2'b11, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0};
        vecs[7]  = '{2'b01, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0};
        vecs[8]  = '{2'b01, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFF9, 1'b0};
        vecs[9]  = '{2'b11, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0};
        vecs[10] = '{2'b11, 32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 32'hFFFFFFFF, 1'b1};
        vecs[11] = '{2'b10, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 32'hFFFFFFFF, 1'b0};
        vecs[12] = '{2'b00, 32'h12345678, 32'h00000010, 32'h00000001, 32'h23456780, 1'b0};
        vecs[13] = '{2'b01, 32'h00000000, 32'hFFFFFFFF, 32'h00000000, 32'h00000000, 1'b0};
        vecs[14] = '{2'b11, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'h00000003, 1'b0};

        rst_n = 1'b0; start = 1'b0; op = 2'b00; rs_data = '0; rt_data = '0;
        #1;
        check("reset_state", {busy, done, div_by_zero, hi, lo}, 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        prev_hi = 32'd0; prev_lo = 32'd0;

        for (int i = 0; i < 15; i++) begin
            launch(vecs[i].op, vecs[i].a, vecs[i].b);
            check($sformatf("v%0d_dz_cleared", i), 64'(div_by_zero), 64'(1'b0));
            finish_op(-1, bcnt, held_ok);
            check_result($sformatf("v%0d", i), vecs[i].hi, vecs[i].lo, vecs[i].dz, bcnt, held_ok);
            @(negedge clk);
            check($sformatf("v%0d_done_width", i), 64'(done), 64'(1'b0));
            prev_hi = vecs[i].hi; prev_lo = vecs[i].lo;
        end

        // Start re-pulsed five cycles into a MULTU must be ignored.
        launch(2'b00, 32'd6, 32'd7);
        finish_op(5, bcnt, held_ok);
        check_result("ignore_start", 32'd0, 32'd42, 1'b0, bcnt, held_ok);
        prev_hi = 32'd0; prev_lo = 32'd42;

        // Start presented during the done cycle is accepted immediately.
        start = 1'b1; op = 2'b10; rs_data = 32'd50; rt_data = 32'd5;
        @(negedge clk);
        start = 1'b0; rs_data = $urandom; rt_data = $urandom;
        check("b2b_busy_rise", 64'(busy), 64'(1'b1));
        check("b2b_done_fall", 64'(done), 64'(1'b0));
        finish_op(-1, bcnt, held_ok);
        // Acceptance cycle is already counted inside finish_op's first sample.
        check_result("b2b", 32'd0, 32'd10, 1'b0, bcnt, held_ok);
        @(negedge clk);
        prev_hi = 32'd0; prev_lo = 32'd10;

        // Reset ten cycles into a MULTU aborts it.
        launch(2'b00, 32'hFFFFFFFF, 32'h00000003);
        repeat (10) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("abort_outputs", {busy, done, div_by_zero, hi, lo}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        held_ok = 1'b1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (done !== 1'b0 || busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) held_ok = 1'b0;
        end
        check("abort_no_done", 64'(held_ok), 64'(1'b1));
        prev_hi = 32'd0; prev_lo = 32'd0;
        launch(2'b10, 32'd9, 32'd3);
        finish_op(-1, bcnt, held_ok);
        check_result("post_reset", 32'd0, 32'd3, 1'b0, bcnt, held_ok);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
